// File: rtl/lc3_ctrl_pkg.sv
// Shared definitions for the LC-3 memory-access sequencer: opcodes, the
// ADDR2MUX encoding and the FSM state encoding.
// Build option LC3_MEM_INDIRECT_EN adds LDI/STI support.
package lc3_ctrl_pkg;

    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_LEA = 4'b1110;

    typedef enum logic [1:0] {
        A2_ZERO   = 2'b00,
        A2_SEXT6  = 2'b01,
        A2_SEXT9  = 2'b10,
        A2_SEXT11 = 2'b11
    } addr2_sel_e;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_CALC     = 4'd1,
        S_RD_WAIT  = 4'd2,
        S_WB       = 4'd3,
        S_ST_MDR   = 4'd4,
        S_WR_WAIT  = 4'd5,
        S_DONE     = 4'd6,
        S_IND_WAIT = 4'd7,
        S_IND_MAR  = 4'd8
    } state_e;

    // Opcodes this sequencer knows how to run; anything else ends in Err.
    function automatic logic op_supported(input logic [3:0] op);
        logic ok;
        ok = (op == OP_LD) || (op == OP_ST) || (op == OP_LDR) ||
             (op == OP_STR) || (op == OP_LEA);
`ifdef LC3_MEM_INDIRECT_EN
        ok = ok || (op == OP_LDI) || (op == OP_STI);
`endif
        return ok;
    endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// 4-bit down counter used to hold SRAM strobes for a fixed number of cycles.
// Loads on state entry, counts to zero and sticks there.
module mem_wait_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       en,
    output logic       zero
);

    logic [3:0] count;

    // Load takes priority; otherwise count down while enabled, never wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= 4'd0;
        else if (load)
            count <= load_val;
        else if (en && count != 4'd0)
            count <= count - 4'd1;
    end

    assign zero = (count == 4'd0);

endmodule

// File: rtl/lc3_mem_access_ctrl.sv
// Sequencer for LC-3 LD/ST/LDR/STR/LEA. All outputs are Moore decodes of the
// state and the latched instruction. Build option LC3_MEM_INDIRECT_EN adds
// LDI/STI through an extra pointer-fetch phase.
module lc3_mem_access_ctrl
    import lc3_ctrl_pkg::*;
#(
    parameter int MEM_WAIT = 2
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Start,
    input  logic [15:0] IR,
    output logic        Busy,
    output logic        Done,
    output logic        Err,
    output logic        ADDR1MUX,
    output logic [1:0]  ADDR2MUX,
    output logic [2:0]  SR1_sel,
    output logic [2:0]  DR_sel,
    output logic        GateMARMUX,
    output logic        GateMDR,
    output logic        GateSR,
    output logic        LD_MAR,
    output logic        LD_MDR,
    output logic        LD_REG,
    output logic        MIO_EN,
    output logic        Mem_OE,
    output logic        Mem_WE
);

    localparam logic [3:0] WAIT_LOAD = 4'(MEM_WAIT - 1);

    state_e      state, nxt;
    logic [15:0] ir_q;
    logic [3:0]  op;
    logic        sup;
    logic        cnt_load, cnt_en, cnt_zero;
    addr2_sel_e  a2;

    // Offset bits never steer the sequencer; they only feed the datapath.
    logic unused_ir;
    assign unused_ir = ^ir_q[5:0];

    assign op  = ir_q[15:12];
    assign sup = op_supported(op);

    // State register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            state <= S_IDLE;
        else
            state <= nxt;
    end

    // Instruction latch, captured only when a request is accepted.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            ir_q <= 16'd0;
        else if (state == S_IDLE && Start)
            ir_q <= IR;
    end

    assign cnt_en = (state == S_RD_WAIT) || (state == S_WR_WAIT) ||
                    (state == S_IND_WAIT);

    mem_wait_counter u_wait (
        .clk      (Clk),
        .rst_n    (Reset_n),
        .load     (cnt_load),
        .load_val (WAIT_LOAD),
        .en       (cnt_en),
        .zero     (cnt_zero)
    );

    assign ADDR2MUX = a2;

    // Next-state and strobe decode.
    always_comb begin
        nxt        = state;
        cnt_load   = 1'b0;
        Busy       = (state != S_IDLE);
        Done       = 1'b0;
        Err        = 1'b0;
        ADDR1MUX   = 1'b0;
        a2         = A2_ZERO;
        SR1_sel    = 3'd0;
        DR_sel     = ir_q[11:9];
        GateMARMUX = 1'b0;
        GateMDR    = 1'b0;
        GateSR     = 1'b0;
        LD_MAR     = 1'b0;
        LD_MDR     = 1'b0;
        LD_REG     = 1'b0;
        MIO_EN     = 1'b0;
        Mem_OE     = 1'b0;
        Mem_WE     = 1'b0;
        case (state)
            S_IDLE: begin
                if (Start)
                    nxt = S_CALC;
            end
            S_CALC: begin
                if (!sup) begin
                    nxt = S_DONE;
                end else begin
                    GateMARMUX = 1'b1;
                    if (op == OP_LDR || op == OP_STR) begin
                        ADDR1MUX = 1'b1;
                        a2       = A2_SEXT6;
                        SR1_sel  = ir_q[8:6];
                    end else begin
                        a2 = A2_SEXT9;
                    end
                    case (op)
                        OP_LEA: begin
                            LD_REG = 1'b1;
                            nxt    = S_DONE;
                        end
                        OP_LD, OP_LDR: begin
                            LD_MAR   = 1'b1;
                            cnt_load = 1'b1;
                            nxt      = S_RD_WAIT;
                        end
`ifdef LC3_MEM_INDIRECT_EN
                        OP_LDI, OP_STI: begin
                            LD_MAR   = 1'b1;
                            cnt_load = 1'b1;
                            nxt      = S_IND_WAIT;
                        end
`endif
                        default: begin
                            LD_MAR = 1'b1;
                            nxt    = S_ST_MDR;
                        end
                    endcase
                end
            end
            S_RD_WAIT: begin
                Mem_OE = 1'b1;
                MIO_EN = 1'b1;
                if (cnt_zero) begin
                    LD_MDR = 1'b1;
                    nxt    = S_WB;
                end
            end
            S_WB: begin
                GateMDR = 1'b1;
                LD_REG  = 1'b1;
                nxt     = S_DONE;
            end
            S_ST_MDR: begin
                SR1_sel  = ir_q[11:9];
                GateSR   = 1'b1;
                LD_MDR   = 1'b1;
                cnt_load = 1'b1;
                nxt      = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                Mem_WE = 1'b1;
                if (cnt_zero)
                    nxt = S_DONE;
            end
`ifdef LC3_MEM_INDIRECT_EN
            S_IND_WAIT: begin
                Mem_OE = 1'b1;
                MIO_EN = 1'b1;
                if (cnt_zero) begin
                    LD_MDR = 1'b1;
                    nxt    = S_IND_MAR;
                end
            end
            S_IND_MAR: begin
                // Pointer fetched into MDR becomes the effective address.
                GateMDR = 1'b1;
                LD_MAR  = 1'b1;
                if (op == OP_LDI) begin
                    cnt_load = 1'b1;
                    nxt      = S_RD_WAIT;
                end else begin
                    nxt = S_ST_MDR;
                end
            end
`endif
            S_DONE: begin
                Done = 1'b1;
                Err  = !sup;
                nxt  = S_IDLE;
            end
            default: nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_lc3_mem_access_ctrl.sv
// Self-checking bench for lc3_mem_access_ctrl: directed cases plus random
// instructions, each compared cycle by cycle against an expected trace.
module tb_lc3_mem_access_ctrl;

    localparam int MW = 2;

    logic        Clk, Reset_n, Start;
    logic [15:0] IR;
    logic        Busy, Done, Err, ADDR1MUX;
    logic [1:0]  ADDR2MUX;
    logic [2:0]  SR1_sel, DR_sel;
    logic        GateMARMUX, GateMDR, GateSR, LD_MAR, LD_MDR, LD_REG;
    logic        MIO_EN, Mem_OE, Mem_WE;

    typedef struct packed {
        logic       busy, done, err, a1;
        logic [1:0] a2;
        logic [2:0] sr1, dr;
        logic       gmar, gmdr, gsr, ldmar, ldmdr, ldreg, mio, oe, we;
    } outs_t;

    outs_t obs;
    assign obs = {Busy, Done, Err, ADDR1MUX, ADDR2MUX, SR1_sel, DR_sel,
                  GateMARMUX, GateMDR, GateSR, LD_MAR, LD_MDR, LD_REG,
                  MIO_EN, Mem_OE, Mem_WE};

    // care: 0 = ignore address selects, 1 = check everything, 2 = check SR1 only
    outs_t exp_q[$];
    int    care_q[$];
    int    total = 0;
    int    bad   = 0;

    lc3_mem_access_ctrl #(.MEM_WAIT(MW)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .IR(IR),
        .Busy(Busy), .Done(Done), .Err(Err),
        .ADDR1MUX(ADDR1MUX), .ADDR2MUX(ADDR2MUX),
        .SR1_sel(SR1_sel), .DR_sel(DR_sel),
        .GateMARMUX(GateMARMUX), .GateMDR(GateMDR), .GateSR(GateSR),
        .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_REG(LD_REG),
        .MIO_EN(MIO_EN), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, want);
        end
    endtask

    // Expected per-cycle outputs for one instruction, from accept+1 through
    // the idle cycle following Done.
    function automatic void build(input logic [15:0] ir);
        outs_t e, base;
        logic [3:0] op;
        bit ld, st, lea, sup;
        op  = ir[15:12];
        ld  = (op == 4'h2) || (op == 4'h6);
        st  = (op == 4'h3) || (op == 4'h7);
        lea = (op == 4'hE);
        sup = ld || st || lea;
        exp_q.delete();
        care_q.delete();
        base = '0;
        base.busy = 1'b1;
        base.dr   = ir[11:9];
        e = base;
        if (sup) begin
            e.gmar = 1'b1;
            if (op == 4'h6 || op == 4'h7) begin
                e.a1 = 1'b1; e.a2 = 2'b01; e.sr1 = ir[8:6];
            end else begin
                e.a2 = 2'b10;
            end
            if (lea) e.ldreg = 1'b1;
            else     e.ldmar = 1'b1;
        end
        exp_q.push_back(e); care_q.push_back(1);
        if (ld) begin
            for (int i = 0; i < MW; i++) begin
                e = base; e.oe = 1'b1; e.mio = 1'b1; e.ldmdr = (i == MW - 1);
                exp_q.push_back(e); care_q.push_back(0);
            end
            e = base; e.gmdr = 1'b1; e.ldreg = 1'b1;
            exp_q.push_back(e); care_q.push_back(0);
        end
        if (st) begin
            e = base; e.sr1 = ir[11:9]; e.gsr = 1'b1; e.ldmdr = 1'b1;
            exp_q.push_back(e); care_q.push_back(2);
            for (int i = 0; i < MW; i++) begin
                e = base; e.we = 1'b1;
                exp_q.push_back(e); care_q.push_back(0);
            end
        end
        e = base; e.done = 1'b1; e.err = !sup;
        exp_q.push_back(e); care_q.push_back(0);
        e = '0; e.dr = ir[11:9];
        exp_q.push_back(e); care_q.push_back(0);
    endfunction

    task automatic run_txn(input logic [15:0] ir, input bit distract);
        outs_t m_sel, m_sr1, m;
        m_sel = '0; m_sel.a1 = 1'b1; m_sel.a2 = 2'b11; m_sel.sr1 = 3'b111;
        m_sr1 = '0; m_sr1.a1 = 1'b1; m_sr1.a2 = 2'b11;
        build(ir);
        Start = 1'b1;
        IR    = ir;
        @(posedge Clk); #1;
        for (int k = 0; k < exp_q.size(); k++) begin
            case (care_q[k])
                1:       m = '1;
                2:       m = ~m_sr1;
                default: m = ~m_sel;
            endcase
            chk($sformatf("ir%h_c%0d", ir, k + 1), 32'(obs & m), 32'(exp_q[k] & m));
            chk("oe_we_excl", 32'(Mem_OE & Mem_WE), 32'd0);
            Start = distract ? 1'($urandom_range(0, 1)) : 1'b0;
            IR    = 16'($urandom);
            if (k + 1 < exp_q.size()) @(posedge Clk); #1;
        end
        Start = 1'b0;
    endtask

    initial begin
        logic [15:0] ir;
        logic [3:0]  op;
        Reset_n = 1'b0;
        Start   = 1'b1;
        IR      = 16'h6283;
        repeat (3) @(posedge Clk);
        #1;
        chk("reset_outs", 32'(obs), 32'd0);
        Start   = 1'b0;
        Reset_n = 1'b1;
        @(posedge Clk); #1;
        chk("post_reset_idle", 32'(obs), 32'd0);

        run_txn(16'h6283, 1'b0);
        run_txn(16'h773F, 1'b0);
        run_txn(16'hEB00, 1'b0);
        run_txn(16'h1042, 1'b0);
        run_txn(16'h6283, 1'b1);

        // Reset while the store is holding Mem_WE.
        Start = 1'b1;
        IR    = 16'h773F;
        @(posedge Clk); #1;
        Start = 1'b0;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        chk("we_before_reset", 32'(Mem_WE), 32'd1);
        #2 Reset_n = 1'b0;
        #1 chk("mid_reset_outs", 32'(obs), 32'd0);
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        run_txn(16'h6283, 1'b0);

        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 5))
                0: op = 4'h2;
                1: op = 4'h3;
                2: op = 4'h6;
                3: op = 4'h7;
                4: op = 4'hE;
                default: op = 4'($urandom_range(0, 15));
            endcase
`ifdef LC3_MEM_INDIRECT_EN
            if (op == 4'hA || op == 4'hB) op = 4'h2;
`endif
            ir = {op, 12'($urandom)};
            run_txn(ir, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
